rsa_mont_decoder: RTL and testbench

//  RSA decryption engine: data_out = data_in^d mod n, with fixed key (n, d) set by parameters.

---
 rtl/rsa_pkg.sv | 34 +++
 rtl/rsa_mont_mul.sv | 96 +++++++++
 rtl/rsa_mont_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_rsa_mont_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA Montgomery decoder slice.
//   - state_t : top-level sequencing states
//   - opsel_t : Montgomery-product operand select codes
//   - RSA_K / MM_CYCLES : default word width and clocks per Montgomery product
//   - mm_cycles() : clocks per Montgomery product for a given word width
package rsa_pkg;

    localparam int unsigned RSA_K     = 12;
    localparam int unsigned MM_CYCLES = RSA_K + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONV_C   = 3'd1,
        ST_CONV_ONE = 3'd2,
        ST_SQUARE   = 3'd3,
        ST_MULT     = 3'd4,
        ST_FINAL    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        SEL_ONE = 3'd0,
        SEL_R2  = 3'd1,
        SEL_C   = 3'd2,
        SEL_XB  = 3'd3,
        SEL_CB  = 3'd4
    } opsel_t;

    // k bit-serial iterations followed by one conditional-subtract cycle.
    function automatic int unsigned mm_cycles(input int unsigned k);
        return k + 1;
    endfunction

endpackage

// File: rtl/rsa_mont_mul.sv
// Bit-serial Montgomery multiplier: res = a*b*2^-k mod n.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   go         : one-cycle request; a/b are consumed on the same edge
//   a, b       : operands (b < n; a may be any k-bit value)
//   res        : reduced product, valid while rdy=1
//   rdy        : high for the single subtract cycle ending the product
// One product occupies exactly k+1 clocks: the go edge performs
// iteration 0, k-1 further iteration edges follow, then the rdy cycle
// presents the conditionally subtracted result combinationally.
module rsa_mont_mul
    import rsa_pkg::*;
#(
    parameter int unsigned n    = 3551,
    parameter int unsigned k    = 12,
    parameter int unsigned logk = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [k-1:0] a,
    input  logic [k-1:0] b,
    output logic [k-1:0] res,
    output logic         rdy
);

    localparam logic [k+1:0]    N_T  = (k+2)'(n);
    localparam logic [logk-1:0] LAST = logk'(mm_cycles(k) - 1);

    logic [k+1:0]    t_q, t_d;
    logic [k-1:0]    a_q, a_d;
    logic [k-1:0]    b_q, b_d;
    logic [logk-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;

    logic            a_bit;
    logic [k-1:0]    b_op;
    logic [k+1:0]    t_cur;
    logic [k+2:0]    sum;
    logic [k+1:0]    t_next;
    logic            last;

    always_comb begin
        // Iteration 0 runs straight off the input operands so that the
        // go edge already does useful work.
        a_bit  = busy_q ? a_q[0] : a[0];
        b_op   = busy_q ? b_q : b;
        t_cur  = busy_q ? t_q : '0;
        sum    = {1'b0, t_cur} + {3'b000, b_op & {k{a_bit}}};
        if (sum[0]) begin
            sum = sum + {1'b0, N_T};
        end
        t_next = sum[k+2:1];
        last   = busy_q && (cnt_q == LAST);

        t_d    = t_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (go && !busy_q) begin
            busy_d = 1'b1;
            a_d    = a >> 1;
            b_d    = b;
            t_d    = t_next;
            cnt_d  = logk'(1);
        end else if (last) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (busy_q) begin
            a_d    = a_q >> 1;
            t_d    = t_next;
            cnt_d  = cnt_q + logk'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign res = k'((t_q >= N_T) ? (t_q - N_T) : t_q);
    assign rdy = last;

endmodule

// File: rtl/rsa_mont_decoder.sv
// RSA decryption engine: data_out = data_in^d mod n with a fixed key,
// using left-to-right square-and-multiply over Montgomery products.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : request, sampled in IDLE
//   data_in   : ciphertext, latched when the operation starts
//   data_out  : plaintext, valid while done=1
//   done      : result ready; cleared one clock after start drops
//   busy      : (only with RSA_DECODER_BUSY_EN) high in every state
//               except IDLE and DONE
// Optional feature macro: RSA_DECODER_BUSY_EN adds the busy port.
module rsa_mont_decoder
    import rsa_pkg::*;
#(
    parameter int unsigned n      = 3551,
    parameter int unsigned d      = 1373,
    parameter int unsigned k      = 12,
    parameter int unsigned logk   = 4,
    parameter int unsigned exp_2k = 2292
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [k-1:0] data_in,
    output logic [k-1:0] data_out,
    output logic         done
`ifdef RSA_DECODER_BUSY_EN
    ,
    output logic         busy
`endif
);

    localparam logic [k-1:0] D_BITS = k'(d);
    localparam logic [k-1:0] R2     = k'(exp_2k);

    state_t          state_q, state_d;
    logic [k-1:0]    c_q, c_d;
    logic [k-1:0]    cb_q, cb_d;
    logic [k-1:0]    xb_q, xb_d;
    logic [logk-1:0] bit_q, bit_d;
    logic [k-1:0]    data_out_q, data_out_d;
    logic            done_q, done_d;
    logic            issue_q, issue_d;

    opsel_t          sel_a, sel_b;
    logic [k-1:0]    mm_a, mm_b, mm_res;
    logic            mm_rdy;

    rsa_mont_mul #(
        .n    (n),
        .k    (k),
        .logk (logk)
    ) u_mm (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (issue_q),
        .a     (mm_a),
        .b     (mm_b),
        .res   (mm_res),
        .rdy   (mm_rdy)
    );

    always_comb begin
        sel_a = SEL_XB;
        sel_b = SEL_XB;
        case (state_q)
            ST_CONV_C:   begin sel_a = SEL_C;   sel_b = SEL_R2;  end
            ST_CONV_ONE: begin sel_a = SEL_ONE; sel_b = SEL_R2;  end
            ST_SQUARE:   begin sel_a = SEL_XB;  sel_b = SEL_XB;  end
            ST_MULT:     begin sel_a = SEL_XB;  sel_b = SEL_CB;  end
            ST_FINAL:    begin sel_a = SEL_XB;  sel_b = SEL_ONE; end
            default:     begin sel_a = SEL_XB;  sel_b = SEL_XB;  end
        endcase

        case (sel_a)
            SEL_ONE: mm_a = k'(1);
            SEL_R2:  mm_a = R2;
            SEL_C:   mm_a = c_q;
            SEL_CB:  mm_a = cb_q;
            default: mm_a = xb_q;
        endcase
        case (sel_b)
            SEL_ONE: mm_b = k'(1);
            SEL_R2:  mm_b = R2;
            SEL_C:   mm_b = c_q;
            SEL_CB:  mm_b = cb_q;
            default: mm_b = xb_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        cb_d       = cb_q;
        xb_d       = xb_q;
        bit_d      = bit_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        issue_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    c_d     = data_in;
                    bit_d   = logk'(k - 1);
                    state_d = ST_CONV_C;
                    issue_d = 1'b1;
                end
            end
            ST_CONV_C: begin
                if (mm_rdy) begin
                    cb_d    = mm_res;
                    state_d = ST_CONV_ONE;
                    issue_d = 1'b1;
                end
            end
            ST_CONV_ONE: begin
                if (mm_rdy) begin
                    xb_d    = mm_res;
                    state_d = ST_SQUARE;
                    issue_d = 1'b1;
                end
            end
            ST_SQUARE: begin
                if (mm_rdy) begin
                    xb_d    = mm_res;
                    issue_d = 1'b1;
                    if (D_BITS[bit_q]) begin
                        state_d = ST_MULT;
                    end else if (bit_q == '0) begin
                        state_d = ST_FINAL;
                    end else begin
                        bit_d = bit_q - logk'(1);
                    end
                end
            end
            ST_MULT: begin
                if (mm_rdy) begin
                    xb_d    = mm_res;
                    issue_d = 1'b1;
                    if (bit_q == '0) begin
                        state_d = ST_FINAL;
                    end else begin
                        bit_d   = bit_q - logk'(1);
                        state_d = ST_SQUARE;
                    end
                end
            end
            ST_FINAL: begin
                if (mm_rdy) begin
                    xb_d    = mm_res;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle publishes the result so data_out and
                // done change together; done is always seen for at least
                // one cycle even if start has already dropped.
                if (!done_q) begin
                    done_d     = 1'b1;
                    data_out_d = xb_q;
                end else if (!start) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            c_q        <= '0;
            cb_q       <= '0;
            xb_q       <= '0;
            bit_q      <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            issue_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            cb_q       <= cb_d;
            xb_q       <= xb_d;
            bit_q      <= bit_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            issue_q    <= issue_d;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;

`ifdef RSA_DECODER_BUSY_EN
    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
`endif

endmodule

// File: tb/tb_rsa_mont_decoder.sv
// Self-checking bench for rsa_mont_decoder: reference results come from
// a plain right-to-left modular exponentiation on (data_in mod n).
module tb_rsa_mont_decoder;

    localparam int unsigned N_MOD  = 3551;
    localparam int unsigned D_EXP  = 1373;
    localparam int unsigned K_W    = 12;
    localparam int unsigned EXP_LAT =
        (K_W + $countones(D_EXP) + 3) * (K_W + 1) + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [K_W-1:0] data_in;
    logic [K_W-1:0] data_out;
    logic           done;
`ifdef RSA_DECODER_BUSY_EN
    logic           busy;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    rsa_mont_decoder #(
        .n      (3551),
        .d      (1373),
        .k      (12),
        .logk   (4),
        .exp_2k (2292)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done)
`ifdef RSA_DECODER_BUSY_EN
        ,
        .busy     (busy)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_modexp(input int unsigned c);
        longint unsigned base = longint'(c % N_MOD);
        longint unsigned r    = 1;
        int unsigned     e    = D_EXP;
        while (e != 0) begin
            if (e[0]) r = (r * base) % N_MOD;
            base = (base * base) % N_MOD;
            e = e >> 1;
        end
        return int'(r);
    endfunction

    // Runs one full operation with start held high, checks latency and
    // result, the hold behaviour in DONE, and the drop back to IDLE.
    task automatic run_op(input logic [K_W-1:0] din, input bit scramble,
                          input string tag, output logic [K_W-1:0] result);
        int unsigned cycles;
        logic [K_W-1:0] expv;
        expv = K_W'(ref_modexp(int'(din)));
        @(negedge clk);
        data_in = din;
        start   = 1'b1;
        @(posedge clk);
        cycles = 0;
        while (cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
`ifdef RSA_DECODER_BUSY_EN
            if (cycles == 1) check({tag, "_busy_hi"}, busy, 1);
`endif
            if (done) break;
            if (scramble) data_in = K_W'($urandom);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_latency"}, cycles, EXP_LAT);
        check({tag, "_result"}, data_out, expv);
`ifdef RSA_DECODER_BUSY_EN
        check({tag, "_busy_lo"}, busy, 0);
`endif
        result = data_out;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_done"}, done, 1);
        check({tag, "_hold_data"}, data_out, expv);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_data_kept"}, data_out, expv);
    endtask

    initial begin
        logic [K_W-1:0] r;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_data", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_done", done, 0);
        check("idle_data", data_out, 0);

        run_op(12'd2959, 1'b0, "c2959", r);
        check("spec_2959", r, 1234);
        run_op(12'd1, 1'b0, "c1", r);
        check("spec_1", r, 1);
        run_op(12'd0, 1'b0, "c0", r);
        check("spec_0", r, 0);
        run_op(12'd3550, 1'b0, "c3550", r);
        check("spec_3550", r, 3550);
        run_op(12'd2959, 1'b1, "scramble", r);
        check("spec_scramble", r, 1234);

        // Abort an operation with reset part way through.
        @(negedge clk);
        data_in = 12'd777;
        start   = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_done", done, 0);
        check("abort_data", data_out, 0);
`ifdef RSA_DECODER_BUSY_EN
        check("abort_busy", busy, 0);
`endif
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(12'd2959, 1'b0, "post_rst", r);
        check("spec_post_rst", r, 1234);

        for (int i = 0; i < 6; i++) begin
            run_op(K_W'($urandom_range(4095, 0)), 1'b0, "rand", r);
        end
        run_op(12'd4000, 1'b0, "over_n", r);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
